// File: rtl/adam_stream_buf.sv
// adam_stream_buf: ready/valid FIFO stream buffer with optional zero-latency fall-through
//   clk        rising-edge clock
//   rst        asynchronous active-high reset of control state
//   flush      synchronous clear of all stored entries
//   slv_data   upstream payload
//   slv_valid  upstream payload valid
//   slv_ready  buffer can accept payload
//   mst_data   downstream payload
//   mst_valid  downstream payload valid
//   mst_ready  downstream accepts payload
//   count      number of stored entries
module adam_stream_buf #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2,
    parameter bit FALL_THROUGH = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        slv_data,
    input  logic                         slv_valid,
    output logic                         slv_ready,
    output logic [DATA_WIDTH-1:0]        mst_data,
    output logic                         mst_valid,
    input  logic                         mst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_live;
    logic                  w_empty;
    logic                  w_bypass;
    logic                  w_slv_fire;
    logic                  w_mst_fire;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // r_live holds slv_ready low from reset until the first clock edge after release
    assign w_empty    = r_count == '0;
    assign w_bypass   = FALL_THROUGH && w_empty;
    assign slv_ready  = r_live && !flush && (r_count < CW'(DEPTH));
    assign mst_valid  = !flush && (w_bypass ? (r_live && slv_valid) : !w_empty);
    assign mst_data   = w_bypass ? slv_data : r_mem[r_rptr];
    assign w_slv_fire = slv_valid && slv_ready;
    assign w_mst_fire = mst_valid && mst_ready;
    // a bypassed word leaves in the same cycle and never touches storage
    assign w_push     = w_slv_fire && !(w_bypass && mst_ready);
    assign w_pop      = w_mst_fire && !w_bypass;
    assign count      = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= f_next(r_wptr);
                if (w_pop) r_rptr <= f_next(r_rptr);
                if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= slv_data;
    end
endmodule

// File: tb/tb_adam_stream_buf.sv
// tb_adam_stream_buf: checks three buffer configurations (2/FT0, 3/FT0, 4/FT1)
module tb_adam_stream_buf;
    typedef struct {
        logic        sv;
        logic [31:0] d;
        logic        mr;
        logic        fl;
        logic        sr;
        logic        mv;
        logic [31:0] md;
        int          cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        sv2 = 0, sr2, mv2, mr2 = 0, fl2 = 0;
    logic [31:0] sd2 = 0, md2;
    logic [1:0]  cnt2;
    logic        sv3 = 0, sr3, mv3, mr3 = 0, fl3 = 0;
    logic [31:0] sd3 = 0, md3;
    logic [1:0]  cnt3;
    logic        sv4 = 0, sr4, mv4, mr4 = 0, fl4 = 0;
    logic [31:0] sd4 = 0, md4;
    logic [2:0]  cnt4;

    logic [31:0] q2[$];
    logic [31:0] q3[$];
    int total = 0, bad = 0, cyc = 0;
    int rx2 = 0, rx3 = 0, lp2 = 0, stall2 = 0;
    vec_t tbl[15];

    always #5 clk = ~clk;

    adam_stream_buf #(.DATA_WIDTH(32), .DEPTH(2), .FALL_THROUGH(1'b0)) u2 (
        .clk(clk), .rst(rst), .flush(fl2), .slv_data(sd2), .slv_valid(sv2), .slv_ready(sr2),
        .mst_data(md2), .mst_valid(mv2), .mst_ready(mr2), .count(cnt2));
    adam_stream_buf #(.DATA_WIDTH(32), .DEPTH(3), .FALL_THROUGH(1'b0)) u3 (
        .clk(clk), .rst(rst), .flush(fl3), .slv_data(sd3), .slv_valid(sv3), .slv_ready(sr3),
        .mst_data(md3), .mst_valid(mv3), .mst_ready(mr3), .count(cnt3));
    adam_stream_buf #(.DATA_WIDTH(32), .DEPTH(4), .FALL_THROUGH(1'b1)) u4 (
        .clk(clk), .rst(rst), .flush(fl4), .slv_data(sd4), .slv_valid(sv4), .slv_ready(sr4),
        .mst_data(md4), .mst_valid(mv4), .mst_ready(mr4), .count(cnt4));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask

    // samples handshakes mid-cycle, runs the scoreboards, then advances past the next rising edge
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (rst) begin
            q2.delete();
            q3.delete();
        end else begin
            if (mv2 && mr2) begin
                if (q2.size() == 0) chk("sb2_unexpected_word", md2, 32'hxxxx_xxxx);
                else begin
                    e = q2.pop_front();
                    chk("sb2_data", md2, e);
                end
                rx2++;
                lp2 = cyc + 1;
            end
            if (sv2 && sr2) q2.push_back(sd2);
            if (sv2 && !sr2) stall2++;
            if (mv3 && mr3) begin
                if (q3.size() == 0) chk("sb3_unexpected_word", md3, 32'hxxxx_xxxx);
                else begin
                    e = q3.pop_front();
                    chk("sb3_data", md3, e);
                end
                rx3++;
            end
            if (sv3 && sr3) q3.push_back(sd3);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        int base, start;
        logic acc;
        tbl[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 0};
        tbl[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 0};
        tbl[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 1};
        tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 2};
        tbl[4]  = '{1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 1};
        tbl[5]  = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 1};
        tbl[6]  = '{1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 2};
        tbl[7]  = '{1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 3};
        tbl[8]  = '{1'b1, 32'h88, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 4};
        tbl[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 3};
        tbl[10] = '{1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 3};
        tbl[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 0};
        tbl[12] = '{1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAA, 0};
        tbl[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'hAA, 1};
        tbl[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 0};

        sv4 = 1'b1;
        #2;
        chk("rst_sr2", {31'b0, sr2}, 0);
        chk("rst_mv2", {31'b0, mv2}, 0);
        chk("rst_cnt2", 32'(cnt2), 0);
        chk("rst_mv4_ft", {31'b0, mv4}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sv4 = 1'b0;
        #1;
        chk("rel_sr2_before_edge", {31'b0, sr2}, 0);
        tick();
        chk("rel_sr2", {31'b0, sr2}, 1);
        chk("rel_sr3", {31'b0, sr3}, 1);
        chk("rel_sr4", {31'b0, sr4}, 1);

        mr2 = 1'b1;
        sv2 = 1'b1;
        sd2 = 32'hA5A5A5A5;
        tick();
        sv2 = 1'b0;
        chk("lat_mv2", {31'b0, mv2}, 1);
        chk("lat_md2", md2, 32'hA5A5A5A5);
        chk("lat_cnt2", 32'(cnt2), 1);
        tick();
        chk("lat_cnt2_back", 32'(cnt2), 0);
        chk("lat_mv2_back", {31'b0, mv2}, 0);

        base = rx2;
        stall2 = 0;
        start = cyc + 1;
        for (int i = 0; i < 100; i++) begin
            sv2 = 1'b1;
            sd2 = i;
            tick();
        end
        sv2 = 1'b0;
        for (int i = 0; i < 10 && rx2 - base < 100; i++) tick();
        chk("tput_words", rx2 - base, 100);
        chk("tput_span", lp2 - start, 100);
        chk("tput_stalls", stall2, 0);
        mr2 = 1'b0;

        for (int i = 0; i < 3; i++) begin
            sv3 = 1'b1;
            sd3 = i;
            tick();
        end
        sv3 = 1'b0;
        chk("full_cnt3", 32'(cnt3), 3);
        chk("full_sr3", {31'b0, sr3}, 0);
        chk("full_head3", md3, 0);
        mr3 = 1'b1;
        for (int i = 3; i < 5; i++) begin
            sv3 = 1'b1;
            sd3 = i;
            acc = 1'b0;
            for (int k = 0; k < 8 && !acc; k++) begin
                acc = sr3;
                tick();
            end
            chk("wrap_accept", {31'b0, acc}, 1);
        end
        sv3 = 1'b0;
        for (int i = 0; i < 10 && cnt3 != 0; i++) tick();
        chk("wrap_rx3", rx3, 5);
        chk("wrap_cnt3", 32'(cnt3), 0);
        chk("wrap_q3_empty", q3.size(), 0);
        mr3 = 1'b0;

        foreach (tbl[i]) begin
            sv4 = tbl[i].sv;
            sd4 = tbl[i].d;
            mr4 = tbl[i].mr;
            fl4 = tbl[i].fl;
            #1;
            chk($sformatf("ft_sr[%0d]", i), {31'b0, sr4}, {31'b0, tbl[i].sr});
            chk($sformatf("ft_mv[%0d]", i), {31'b0, mv4}, {31'b0, tbl[i].mv});
            chk($sformatf("ft_cnt[%0d]", i), 32'(cnt4), tbl[i].cnt);
            if (tbl[i].mv) chk($sformatf("ft_md[%0d]", i), md4, tbl[i].md);
            tick();
        end
        sv4 = 1'b0;
        mr4 = 1'b0;
        fl4 = 1'b0;

        sv2 = 1'b1;
        sd2 = 32'h100;
        tick();
        sd2 = 32'h101;
        tick();
        sv2 = 1'b0;
        chk("mid_cnt2_full", 32'(cnt2), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_sr2", {31'b0, sr2}, 0);
        chk("mid_rst_mv2", {31'b0, mv2}, 0);
        chk("mid_rst_cnt2", 32'(cnt2), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rel_sr2_before_edge", {31'b0, sr2}, 0);
        tick();
        chk("mid_rel_sr2", {31'b0, sr2}, 1);
        mr2 = 1'b1;
        base = rx2;
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_stale_mv2", {31'b0, mv2}, 0);
            tick();
        end
        sv2 = 1'b1;
        sd2 = 32'h55;
        tick();
        sv2 = 1'b0;
        tick();
        chk("mid_rx2", rx2 - base, 1);
        chk("mid_q2_empty", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adam_stream_buf.md
ADAM_STREAM_BUF -- requirements
Module: adam_stream_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 2: storage entries, SHALL be >= 2; non-power-of-two values SHALL be supported.
REQ-003 Parameter FALL_THROUGH, default 0: 0 = registered output, 1 = zero-latency bypass when empty.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous clear of all stored entries.
REQ-007 slv_data  input  DATA_WIDTH  upstream payload.
REQ-008 slv_valid  input  1  upstream payload valid.
REQ-009 slv_ready  output  1  buffer accepts payload.
REQ-010 mst_data  output  DATA_WIDTH  downstream payload.
REQ-011 mst_valid  output  1  downstream payload valid.
REQ-012 mst_ready  input  1  downstream accepts payload.
REQ-013 count  output  $clog2(DEPTH+1)  number of stored entries.

Function
REQ-014 Transfer on a port SHALL occur exactly in cycles where valid and ready are both high at the rising edge of clk.
REQ-015 Payload order SHALL be strictly FIFO; no entry SHALL be dropped, duplicated or reordered.
REQ-016 Storage: circular buffer, write pointer and read pointer each in 0..DEPTH-1, wrapping from DEPTH-1 to 0.
REQ-017 count SHALL increment on push-only, decrement on pop-only, hold on simultaneous push and pop or idle.
REQ-018 slv_ready SHALL be high iff count < DEPTH and flush is low; it SHALL NOT depend combinationally on mst_ready.
REQ-019 FALL_THROUGH=0: mst_valid SHALL be high iff count > 0; mst_data SHALL be the entry at the read pointer; latency from slv transfer to mst_valid = 1 cycle.
REQ-020 FALL_THROUGH=0, DEPTH>=2: sustained full throughput (one transfer per cycle each side) SHALL be achieved when mst_ready is held high.
REQ-021 FALL_THROUGH=1, count = 0: mst_valid SHALL equal slv_valid and mst_data SHALL equal slv_data combinationally (latency 0).
REQ-022 FALL_THROUGH=1, count = 0, slv and mst transfer in same cycle: payload SHALL bypass storage; count stays 0.
REQ-023 FALL_THROUGH=1, count = 0, slv transfer without mst_ready: payload SHALL be stored; count becomes 1.
REQ-024 FALL_THROUGH=1, count > 0: behaviour SHALL equal REQ-019 (stored head presented, no bypass).
REQ-025 Full (count = DEPTH) with mst transfer: slv_ready SHALL be low that cycle; count becomes DEPTH-1; slv_ready high next cycle.
REQ-026 Empty with FALL_THROUGH=0: mst_valid low regardless of slv_valid.
REQ-027 mst_valid, once high, SHALL remain high with mst_data stable until an mst transfer or flush.
REQ-028 flush high at a rising edge: count, read and write pointers SHALL become 0; any slv or mst transfer that cycle SHALL be discarded; mst_valid SHALL be forced low while flush is high.
REQ-029 Payload storage SHALL not be required to reset; only control state resets.

Reset
REQ-030 rst high SHALL immediately clear count and both pointers to 0, drive slv_ready = 0, mst_valid = 0, mst_data unconstrained.
REQ-031 slv_ready SHALL rise on the first rising edge of clk after rst deasserts.
REQ-032 rst asserted mid-operation SHALL discard all stored entries; no stale entry SHALL appear after release.

Verification
REQ-033 DEPTH=2, FT=0: send 0xA5A5A5A5, mst_ready high -> mst_valid high 1 cycle after slv transfer, data 0xA5A5A5A5, count returns to 0.
REQ-034 DEPTH=3, FT=0, mst_ready low: push 0,1,2 -> count = 3, slv_ready low; then mst_ready high -> 0,1,2 received in order, wrap past pointer 2 on pushes 3,4 correct.
REQ-035 DEPTH=4, FT=1: empty, slv_valid and mst_ready high, data 0x11 -> mst_data 0x11 same cycle, count stays 0.
REQ-036 DEPTH=2, FT=0: 100 back-to-back words 0..99, mst_ready high -> 100 transfers in 101 cycles, order preserved.
REQ-037 DEPTH=4, count = 3, flush pulse with simultaneous slv transfer -> count = 0, mst_valid low next cycle, next received word is first pushed after flush.
REQ-038 DEPTH=2, count = 2, rst pulse mid-stream -> slv_ready and mst_valid low immediately, count = 0, no stale word received after release.
